// File: rtl/inst_rom_resp_pkg.sv
// Shared types and constants for the instruction-memory responder and its storage array.
package inst_rom_resp_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;
  localparam int CNT_W       = 4;

  localparam logic [INST_W-1:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ROM_ST_IDLE = 2'b00,
    ROM_ST_WAIT = 2'b01,
    ROM_ST_DONE = 2'b10
  } rom_state_e;

  function automatic logic word_misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/inst_rom_array.sv
// DEPTH x 32 instruction storage: synchronous write, synchronous read into a clearable
// output register so the responder's data output comes straight from a flop.
module inst_rom_array
  import inst_rom_resp_pkg::*;
#(
  parameter int                DEPTH    = 1024,
  parameter logic [INST_W-1:0] NOP_WORD = ZERO_WORD,
  parameter int                IDX_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  addr,
  input  logic              we,
  input  logic [INST_W-1:0] wdata,
  input  logic              rd_en,
  input  logic              rd_clr,
  output logic [INST_W-1:0] rdata
);

  logic [INST_W-1:0] mem_r [DEPTH];
  logic [INST_W-1:0] rdata_r;

  // Storage write port; contents are deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Read register: load on a read, fall back to NOP when no valid word is presented
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_r <= NOP_WORD;
    end else if (rd_en) begin
      rdata_r <= mem_r[addr];
    end else if (rd_clr) begin
      rdata_r <= NOP_WORD;
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/inst_rom_resp.sv
// Instruction-memory responder: fetch FSM, wait-state counter, address decode and load port
// in front of a single-port instruction array.
module inst_rom_resp
  import inst_rom_resp_pkg::*;
#(
  parameter int                DEPTH       = 1024,
  parameter int                WAIT_CYCLES = 0,
  parameter logic [INST_W-1:0] NOP_WORD    = ZERO_WORD
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rom_ce_i,
  input  logic [INST_ADDR_W-1:0] rom_addr_i,
  output logic [INST_W-1:0]      rom_data_o,
  output logic                   rom_ready_o,
  output logic                   stallreq_o,
  output logic                   addr_err_o,
  input  logic                   load_we_i,
  input  logic [INST_ADDR_W-1:0] load_addr_i,
  input  logic [INST_W-1:0]      load_data_i
);

  localparam int               IDX_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_CYCLES);

  rom_state_e             state_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [INST_ADDR_W-1:0] req_addr_r;
  logic                   ready_r;
  logic                   err_r;

  logic             addr_bad_s;
  logic             load_bad_s;
  logic             same_addr_s;
  logic             capture_s;
  logic             wait_done_s;
  logic             hold_s;
  logic             rd_en_s;
  logic             rd_clr_s;
  logic             wr_en_s;
  logic             load_err_s;
  logic [IDX_W-1:0] mem_idx_s;

  // Misaligned, or any bit above the word index set
  function automatic logic addr_bad(input logic [INST_ADDR_W-1:0] a);
    return word_misaligned(a[1:0]) || ((a >> (IDX_W + 2)) != {INST_ADDR_W{1'b0}});
  endfunction

  // Request decode: capture, wait expiry, array read/clear and load qualification
  always_comb begin
    addr_bad_s  = addr_bad(rom_addr_i);
    load_bad_s  = addr_bad(load_addr_i);
    same_addr_s = (rom_addr_i == req_addr_r);
    capture_s   = 1'b0;
    wait_done_s = 1'b0;
    if (rom_ce_i) begin
      case (state_r)
        ROM_ST_IDLE: capture_s = 1'b1;
        ROM_ST_WAIT: begin
          capture_s   = ~same_addr_s;
          wait_done_s = same_addr_s & (cnt_r <= CNT_W'(1));
        end
        ROM_ST_DONE: capture_s = ~same_addr_s;
        default:     capture_s = 1'b1;
      endcase
    end else begin
      capture_s = 1'b0;
    end
    hold_s     = rom_ce_i & (state_r == ROM_ST_DONE) & same_addr_s;
    // A zero-wait capture reads on the capture edge; otherwise read when the wait expires
    rd_en_s    = (capture_s & ~addr_bad_s & (WAIT_CNT == CNT_W'(0))) | wait_done_s;
    rd_clr_s   = ~(rd_en_s | hold_s);
    wr_en_s    = load_we_i & ~rom_ce_i & ~load_bad_s;
    load_err_s = load_we_i & (rom_ce_i | load_bad_s);
    mem_idx_s  = rom_ce_i ? rom_addr_i[IDX_W+1:2] : load_addr_i[IDX_W+1:2];
  end

  // Fetch FSM with registered ready flag and one-cycle error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ROM_ST_IDLE;
      cnt_r      <= CNT_W'(0);
      req_addr_r <= {INST_ADDR_W{1'b0}};
      ready_r    <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      err_r <= (capture_s & addr_bad_s) | load_err_s;
      if (!rom_ce_i) begin
        state_r <= ROM_ST_IDLE;
        cnt_r   <= CNT_W'(0);
        ready_r <= 1'b0;
      end else if (capture_s) begin
        req_addr_r <= rom_addr_i;
        cnt_r      <= WAIT_CNT;
        if (addr_bad_s || (WAIT_CNT == CNT_W'(0))) begin
          state_r <= ROM_ST_DONE;
          ready_r <= 1'b1;
        end else begin
          state_r <= ROM_ST_WAIT;
          ready_r <= 1'b0;
        end
      end else if (wait_done_s) begin
        state_r <= ROM_ST_DONE;
        cnt_r   <= CNT_W'(0);
        ready_r <= 1'b1;
      end else if (state_r == ROM_ST_WAIT) begin
        cnt_r <= cnt_r - CNT_W'(1);
      end else begin
        state_r <= state_r;
      end
    end
  end

  inst_rom_array #(
    .DEPTH    (DEPTH),
    .NOP_WORD (NOP_WORD),
    .IDX_W    (IDX_W)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .addr   (mem_idx_s),
    .we     (wr_en_s),
    .wdata  (load_data_i),
    .rd_en  (rd_en_s),
    .rd_clr (rd_clr_s),
    .rdata  (rom_data_o)
  );

  assign rom_ready_o = ready_r;
  assign addr_err_o  = err_r;
  // Reset gates the request so the fetch port sees no stall while rst is held
  assign stallreq_o  = ~rst & rom_ce_i & ~(ready_r & same_addr_s);

endmodule

// File: tb/tb_inst_rom_resp.sv
// Directed plus randomized bench: two responders (0 and 3 wait states) share one stimulus
// stream and are compared against a cycle-age reference model.
module tb_inst_rom_resp;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic        we;
  logic [31:0] laddr;
  logic [31:0] ldata;

  logic [31:0] data0, data3;
  logic        rdy0, rdy3, stall0, stall3, err0, err3;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: a request is valid once it has aged wait_of[k] edges past its capture
  logic [31:0] mem_m [DEPTH];
  bit          have_m [2];
  logic [31:0] req_m [2];
  bit          bad_m [2];
  int          t0_m [2];
  int          cyc_m;
  int          wait_of [2] = '{0, 3};
  logic        exp_rdy [2];
  logic        exp_err [2];
  logic [31:0] exp_data [2];

  always #5 clk = ~clk;

  inst_rom_resp #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .NOP_WORD(NOP)) u_w0 (
    .clk(clk), .rst(rst), .rom_ce_i(rom_ce), .rom_addr_i(rom_addr),
    .rom_data_o(data0), .rom_ready_o(rdy0), .stallreq_o(stall0), .addr_err_o(err0),
    .load_we_i(we), .load_addr_i(laddr), .load_data_i(ldata)
  );

  inst_rom_resp #(.DEPTH(DEPTH), .WAIT_CYCLES(3), .NOP_WORD(NOP)) u_w3 (
    .clk(clk), .rst(rst), .rom_ce_i(rom_ce), .rom_addr_i(rom_addr),
    .rom_data_o(data3), .rom_ready_o(rdy3), .stallreq_o(stall3), .addr_err_o(err3),
    .load_we_i(we), .load_addr_i(laddr), .load_data_i(ldata)
  );

  function automatic bit bad_addr(input logic [31:0] a);
    return ((a % 32'd4) != 32'd0) || (a >= 32'(DEPTH * 4));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, expv, cyc_m);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      have_m[k]   = 1'b0;
      req_m[k]    = 32'h0;
      bad_m[k]    = 1'b0;
      exp_rdy[k]  = 1'b0;
      exp_data[k] = NOP;
      exp_err[k]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit lerr;
    lerr = we && (rom_ce || bad_addr(laddr));
    if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        exp_err[k] = lerr;
        if (!rom_ce) begin
          have_m[k]   = 1'b0;
          exp_rdy[k]  = 1'b0;
          exp_data[k] = NOP;
        end else begin
          if (!have_m[k] || rom_addr != req_m[k]) begin
            have_m[k] = 1'b1;
            req_m[k]  = rom_addr;
            t0_m[k]   = cyc_m;
            bad_m[k]  = bad_addr(rom_addr);
            if (bad_m[k]) exp_err[k] = 1'b1;
          end
          exp_rdy[k]  = bad_m[k] || (cyc_m - t0_m[k] >= wait_of[k]);
          exp_data[k] = (!exp_rdy[k] || bad_m[k]) ? NOP : mem_m[int'(req_m[k] >> 2)];
        end
      end
      if (we && !rom_ce && !bad_addr(laddr)) mem_m[int'(laddr >> 2)] = ldata;
    end
    cyc_m++;
  endtask

  task automatic chk_stall();
    chk("stall_w0", 32'(stall0), 32'(!rst && rom_ce && !(exp_rdy[0] && rom_addr == req_m[0])));
    chk("stall_w3", 32'(stall3), 32'(!rst && rom_ce && !(exp_rdy[1] && rom_addr == req_m[1])));
  endtask

  task automatic chk_regs();
    chk("ready_w0", 32'(rdy0), 32'(exp_rdy[0]));
    chk("data_w0",  data0,     exp_data[0]);
    chk("err_w0",   32'(err0), 32'(exp_err[0]));
    chk("ready_w3", 32'(rdy3), 32'(exp_rdy[1]));
    chk("data_w3",  data3,     exp_data[1]);
    chk("err_w3",   32'(err3), 32'(exp_err[1]));
  endtask

  task automatic cycle(input bit c, input logic [31:0] a, input bit lw,
                       input logic [31:0] la, input logic [31:0] ld);
    rom_ce = c; rom_addr = a; we = lw; laddr = la; ldata = ld;
    #1;
    chk_stall();
    @(posedge clk);
    model_edge();
    #1;
    chk_regs();
    chk_stall();
  endtask

  task automatic fetch(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, a, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    cycle(1'b0, 32'h0, 1'b1, a, d);
  endtask

  // Asynchronous reset asserted between edges must clear outputs before the next edge
  task automatic rst_mid();
    rst = 1'b1;
    #1;
    model_reset();
    chk_regs();
    chk_stall();
    @(posedge clk);
    model_edge();
    #1;
    chk_regs();
    chk_stall();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr(input int good_pct);
    int r;
    logic [31:0] idx;
    r   = $urandom_range(0, 99);
    idx = 32'($urandom_range(0, 15)) * 32'd4;
    if (r < good_pct)      return idx;
    else if (r < good_pct + (100 - good_pct) / 2)
                           return idx + 32'($urandom_range(1, 3));
    else                   return 32'(DEPTH * 4) + idx + (32'($urandom_range(0, 7)) << 16);
  endfunction

  initial begin
    logic [31:0] ra;
    int r;
    rst = 1'b1; rom_ce = 1'b1; rom_addr = 32'h0; we = 1'b0; laddr = 32'h0; ldata = 32'h0;
    cyc_m = 0;
    model_reset();

    // 1: reset held with fetch enabled
    fetch(32'h0, 2);
    rst = 1'b0;

    // Preload the low words
    load(32'h0000_0000, 32'h3401_0020);
    load(32'h0000_0004, 32'h3402_0040);
    for (int i = 2; i < 16; i++) load(32'(i * 4), $urandom);

    // 1/2: fetch 0 then back-to-back 0x4 / 0x0 / 0x4
    fetch(32'h0, 2);
    fetch(32'h4, 4);
    fetch(32'h0, 1);
    fetch(32'h4, 1);
    fetch(32'h0, 1);

    // 3: long wait on 0x4, then redirect to 0x0 mid-wait
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    fetch(32'h4, 5);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    fetch(32'h4, 2);
    fetch(32'h0, 5);

    // 4: misaligned and out-of-range fetches
    fetch(32'h2, 2);
    fetch(32'(DEPTH * 4), 2);
    fetch(32'h0, 4);

    // 5: load while fetching is dropped; bad load addresses are ignored
    cycle(1'b1, 32'h0, 1'b1, 32'h0, 32'hFFFF_FFFF);
    fetch(32'h0, 2);
    load(32'h0000_0001, 32'hDEAD_BEEF);
    load(32'(DEPTH * 4), 32'hDEAD_BEEF);
    fetch(32'h0, 4);
    fetch(32'h4, 1);

    // 6: reset in the middle of a wait, then a clean fetch
    fetch(32'h8, 2);
    rst_mid();
    fetch(32'h4, 5);

    // Randomized traffic
    ra = 32'h0;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8) begin
        cycle(1'b0, ra, 1'b1, rand_addr(80), $urandom);
      end else if (r < 12) begin
        cycle(1'b0, ra, 1'b0, 32'h0, 32'h0);
      end else begin
        if ($urandom_range(0, 99) < 30) ra = rand_addr(80);
        cycle(1'b1, ra, ($urandom_range(0, 19) == 0), rand_addr(80), $urandom);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
